// File: rtl/sync_ram_pkg.sv
// Shared types for the dual-port RAM: clear-sequencer state and collision policy codes.
package sync_ram_pkg;

    typedef enum logic {
        CLR = 1'b0,
        RUN = 1'b1
    } state_t;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    function automatic logic byte_par(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/sync_ram_dp_if.sv
// Port bundle for sync_ram_dp; rd_perr exists only when SYNC_RAM_DP_PARITY_EN is defined.
interface sync_ram_dp_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W/8-1:0]   wr_be;
    logic                  rd_en;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_W-1:0]     rd_data;
    logic                  rd_valid;
    logic                  init_busy;
`ifdef SYNC_RAM_DP_PARITY_EN
    logic                  rd_perr;
`endif

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
`ifdef SYNC_RAM_DP_PARITY_EN
        input  rd_perr,
`endif
        input  rd_data, rd_valid, init_busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr,
`ifdef SYNC_RAM_DP_PARITY_EN
        output rd_perr,
`endif
        output rd_data, rd_valid, init_busy
    );

endinterface

// File: rtl/sync_ram_clr.sv
// Clear sequencer: walks addresses 0..DEPTH-1 once after reset, then parks in RUN.
// Latency: CLR lasts exactly DEPTH cycles after reset release.
// Backpressure: none; the RAM ignores user traffic while init_busy is high.
module sync_ram_clr
    import sync_ram_pkg::*;
#(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    output state_t            state,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              clr_we,
    output logic              init_busy
);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] ptr_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLR;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        case (state)
            CLR: begin
                ptr_nxt = ptr + 1'b1;
                if (ptr == LAST_ADDR)
                    state_nxt = RUN;
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = CLR;
        endcase
    end

    always_comb begin
        clr_we    = (state == CLR);
        init_busy = (state == CLR);
        clr_addr  = ptr;
    end

endmodule

// File: rtl/sync_ram_dp.sv
// One-write/one-read synchronous RAM with byte enables and self-clear after reset.
// Latency: 1 cycle read; same-address collision resolved by RD_MODE (0 old data, 1 new data).
// Backpressure: none; optional per-byte parity via SYNC_RAM_DP_PARITY_EN.
module sync_ram_dp
    import sync_ram_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 3,
    parameter int                RD_MODE   = RD_FIRST,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input logic          clk,
    input logic          rst_n,
    sync_ram_dp_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int NB    = DATA_W / 8;

    state_t            state;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_we;
    logic              init_busy;
    logic              run;

    sync_ram_clr #(.ADDR_W(ADDR_W)) u_clr (
        .clk       (clk),
        .rst_n     (rst_n),
        .state     (state),
        .clr_addr  (clr_addr),
        .clr_we    (clr_we),
        .init_busy (init_busy)
    );

    assign run           = (state == RUN);
    assign bus.init_busy = init_busy;

    // Storage has no reset network; the clear sequence is the only initialiser.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_next;
    logic              collide;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;

    assign collide = bus.wr_en && (bus.wr_addr == bus.rd_addr);

    always_comb begin
        rd_next = mem[bus.rd_addr];
        if (RD_MODE == WR_FIRST && collide) begin
            for (int b = 0; b < NB; b++)
                if (bus.wr_be[b]) rd_next[8*b +: 8] = bus.wr_data[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= CLEAR_VAL;
        end else if (run && bus.wr_en) begin
            for (int b = 0; b < NB; b++)
                if (bus.wr_be[b]) mem[bus.wr_addr][8*b +: 8] <= bus.wr_data[8*b +: 8];
        end
    end

`ifdef SYNC_RAM_DP_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic [NB-1:0] clr_par;
    logic [NB-1:0] rd_par_next;
    logic          perr_next;
    logic          rd_perr_q;

    always_comb begin
        clr_par = '0;
        for (int b = 0; b < NB; b++) clr_par[b] = byte_par(CLEAR_VAL[8*b +: 8]);
    end

    // Bypassed bytes carry freshly computed parity, matching what gets stored.
    always_comb begin
        rd_par_next = par[bus.rd_addr];
        if (RD_MODE == WR_FIRST && collide) begin
            for (int b = 0; b < NB; b++)
                if (bus.wr_be[b]) rd_par_next[b] = byte_par(bus.wr_data[8*b +: 8]);
        end
        perr_next = 1'b0;
        for (int b = 0; b < NB; b++)
            perr_next = perr_next | (rd_par_next[b] ^ byte_par(rd_next[8*b +: 8]));
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            par[clr_addr] <= clr_par;
        end else if (run && bus.wr_en) begin
            for (int b = 0; b < NB; b++)
                if (bus.wr_be[b]) par[bus.wr_addr][b] <= byte_par(bus.wr_data[8*b +: 8]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 rd_perr_q <= 1'b0;
        else if (run && bus.rd_en)  rd_perr_q <= perr_next;
    end

    assign bus.rd_perr = rd_perr_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= run && bus.rd_en;
            if (run && bus.rd_en) rd_data_q <= rd_next;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_sync_ram_dp.sv
// Drives a read-first and a write-first instance with identical traffic and scoreboards both.
module tb_sync_ram_dp;
    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [15:0] d;
        logic        p;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_ram_dp_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
    sync_ram_dp_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();

    sync_ram_dp #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(0), .CLEAR_VAL(16'h0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0));
    sync_ram_dp #(.DATA_W(DW), .ADDR_W(AW), .RD_MODE(1), .CLEAR_VAL(16'h0000)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(if1));

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] mdl [DEPTH];
    exp_t        qs [2][$];
    logic [15:0] hold [2];
    logic        flipped3 = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic drive(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic [1:0] be, input logic re, input logic [2:0] ra);
        if0.wr_en = we; if0.wr_addr = wa; if0.wr_data = wd; if0.wr_be = be;
        if0.rd_en = re; if0.rd_addr = ra;
        if1.wr_en = we; if1.wr_addr = wa; if1.wr_data = wd; if1.wr_be = be;
        if1.rd_en = re; if1.rd_addr = ra;
    endtask

    // Reference: read-first sees the old word, write-first sees it with enabled bytes replaced.
    task automatic op(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                      input logic [1:0] be, input logic re, input logic [2:0] ra);
        exp_t e0, e1;
        @(negedge clk);
        e0.d = mdl[ra];
        e0.p = flipped3 && (ra == 3'd3);
        e1   = e0;
        if (we && wa == ra)
            for (int b = 0; b < 2; b++)
                if (be[b]) e1.d[8*b +: 8] = wd[8*b +: 8];
        if (re) begin
            qs[0].push_back(e0);
            qs[1].push_back(e1);
        end
        if (we)
            for (int b = 0; b < 2; b++)
                if (be[b]) mdl[wa][8*b +: 8] = wd[8*b +: 8];
        drive(we, wa, wd, be, re, ra);
    endtask

    task automatic idle();
        op(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0);
    endtask

    task automatic mon(input int m, input logic v, input logic [15:0] d,
                       output exp_t e, output logic got);
        got = 1'b0;
        e   = '0;
        if (v) begin
            if (qs[m].size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_rd_valid m%0d: got rd_valid=1 required 0", m);
            end else begin
                e   = qs[m].pop_front();
                got = 1'b1;
                check($sformatf("rd_data_m%0d", m), 32'(d), 32'(e.d));
                hold[m] = e.d;
            end
        end else begin
            check($sformatf("rd_hold_m%0d", m), 32'(d), 32'(hold[m]));
        end
    endtask

    always @(negedge clk) begin
        exp_t e0, e1;
        logic g0, g1;
        mon(0, if0.rd_valid, if0.rd_data, e0, g0);
        mon(1, if1.rd_valid, if1.rd_data, e1, g1);
`ifdef SYNC_RAM_DP_PARITY_EN
        if (g0) check("rd_perr_m0", 32'(if0.rd_perr), 32'(e0.p));
        if (g1) check("rd_perr_m1", 32'(if1.rd_perr), 32'(e1.p));
`endif
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_valid_m0"},  32'(if0.rd_valid),  32'd0);
        check({tag, "_rd_valid_m1"},  32'(if1.rd_valid),  32'd0);
        check({tag, "_rd_data_m0"},   32'(if0.rd_data),   32'd0);
        check({tag, "_rd_data_m1"},   32'(if1.rd_data),   32'd0);
        check({tag, "_init_busy_m0"}, 32'(if0.init_busy), 32'd1);
        check({tag, "_init_busy_m1"}, 32'(if1.init_busy), 32'd1);
    endtask

    task automatic model_reset();
        for (int a = 0; a < DEPTH; a++) mdl[a] = 16'h0000;
        hold[0]  = 16'h0;
        hold[1]  = 16'h0;
        flipped3 = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        check({tag, "_pending_reads"}, 32'(qs[0].size() + qs[1].size()), 32'd0);
        model_reset();
    endtask

    // Release reset and count CLR cycles while hammering wr_en/rd_en, which must be ignored.
    task automatic release_clear(input int abort_at);
        int cnt = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!if0.init_busy) break;
            cnt++;
            check("init_busy_agree", 32'(if1.init_busy), 32'd1);
            if (abort_at != 0 && cnt == abort_at) begin
                drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0);
                #2 rst_n = 1'b0;
                #1;
                check_reset_outputs("clr_abort");
                model_reset();
                return;
            end
            drive(1'b1, 3'($urandom_range(0, 7)), 16'($urandom), 2'b11,
                  1'b1, 3'($urandom_range(0, 7)));
        end
        drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0);
        check("init_busy_cycles", 32'(cnt), 32'd8);
    endtask

    initial begin
        drive(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0);
        model_reset();
        #1;
        check_reset_outputs("por");
        repeat (3) @(posedge clk);
        release_clear(4);
        repeat (2) @(posedge clk);
        release_clear(0);

        for (int a = 0; a < DEPTH; a++) op(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'(a));
        idle();

        op(1'b1, 3'd2, 16'hA5C3, 2'b01, 1'b0, 3'd0);
        op(1'b0, 3'd0, 16'h0,    2'b00, 1'b1, 3'd2);
        idle();
        idle();

        op(1'b1, 3'd5, 16'h1111, 2'b11, 1'b0, 3'd0);
        op(1'b1, 3'd5, 16'h2222, 2'b11, 1'b1, 3'd5);
        op(1'b0, 3'd0, 16'h0,    2'b00, 1'b1, 3'd5);
        idle();

        for (int i = 0; i < 400; i++) begin
            op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
        end
        idle();

        op(1'b1, 3'd7, 16'hBEEF, 2'b11, 1'b0, 3'd0);
        op(1'b0, 3'd0, 16'h0,    2'b00, 1'b1, 3'd7);
        idle();
        do_reset("run_reset");
        release_clear(0);
        op(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd7);
        idle();

`ifdef SYNC_RAM_DP_PARITY_EN
        @(negedge clk);
        dut0.mem[3] <= dut0.mem[3] ^ 16'h0200;
        dut1.mem[3] <= dut1.mem[3] ^ 16'h0200;
        mdl[3]   = mdl[3] ^ 16'h0200;
        flipped3 = 1'b1;
        op(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd3);
        op(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'd4);
        idle();
`endif

        repeat (3) idle();
        check("leftover_m0", 32'(qs[0].size()), 32'd0);
        check("leftover_m1", 32'(qs[1].size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_ram_dp.md
SYNC_RAM_DP -- requirements
Module: sync_ram_dp

Interface
REQ-001 Parameter DATA_W, default 8, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 3, address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter RD_MODE, default 0, same-address collision policy: 0 = read-first (old data), 1 = write-first (new data).
REQ-004 Parameter CLEAR_VAL, default 0, DATA_W-bit value written to every word during initialisation.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 wr_en  in  1  write request.
REQ-008 wr_addr  in  ADDR_W  write address.
REQ-009 wr_data  in  DATA_W  write data.
REQ-010 wr_be  in  DATA_W/8  byte enables; bit i covers wr_data[8i+7:8i].
REQ-011 rd_en  in  1  read request.
REQ-012 rd_addr  in  ADDR_W  read address.
REQ-013 rd_data  out  DATA_W  registered read data.
REQ-014 rd_valid  out  1  one-cycle pulse marking rd_data as fresh.
REQ-015 init_busy  out  1  high while the memory is being cleared.

Function
REQ-016 Control FSM SHALL have two states: CLR (initialising) and RUN.
REQ-017 In CLR, one word per cycle SHALL be written with CLEAR_VAL, addresses 0 to DEPTH-1 ascending; after writing DEPTH-1 the FSM SHALL enter RUN on the next edge; CLR lasts exactly DEPTH cycles.
REQ-018 init_busy SHALL be 1 in CLR and 0 in RUN.
REQ-019 In CLR, wr_en and rd_en SHALL be ignored; rd_valid SHALL remain 0.
REQ-020 In RUN, a write with wr_en=1 SHALL update only the bytes of mem[wr_addr] whose wr_be bit is 1; wr_be=0 SHALL leave memory unchanged.
REQ-021 In RUN, rd_en=1 at edge N SHALL present mem[rd_addr] on rd_data with rd_valid=1 after edge N; read latency is 1 cycle.
REQ-022 When rd_en=0, rd_data SHALL hold its last value and rd_valid SHALL be 0 on the next cycle.
REQ-023 Same-cycle read and write to the same address: RD_MODE=0 SHALL return pre-write data; RD_MODE=1 SHALL return pre-write data with enabled bytes replaced by wr_data.
REQ-024 Read and write to different addresses in the same cycle SHALL both complete without interaction.
REQ-025 Addresses SHALL wrap naturally; no out-of-range condition exists.

Reset
REQ-026 rst_n low SHALL immediately force state=CLR, clear pointer=0, rd_data=0, rd_valid=0, init_busy=1.
REQ-027 Reset asserted mid-clear or mid-operation SHALL abort the current activity; full clearing SHALL restart from address 0 after release.
REQ-028 Memory contents SHALL NOT require a reset network; clearing is done solely by the CLR sequence.

Configuration
REQ-029 Macro SYNC_RAM_DP_PARITY_EN SHALL, when defined, store one even-parity bit per byte and add output rd_perr (1 bit), valid with rd_valid and high if any byte of the read word fails parity; CLR SHALL write correct parity.
REQ-030 Without SYNC_RAM_DP_PARITY_EN, neither the parity storage nor the rd_perr port SHALL exist; behaviour is otherwise identical.

Structure
REQ-031 Shared package sync_ram_pkg SHALL hold the FSM state type (CLR, RUN) and the RD_MODE constants RD_FIRST=0 and WR_FIRST=1.
REQ-032 The clear sequencer (FSM, address counter, init_busy) SHALL be the sub-module sync_ram_clr; the storage array and read path stay in sync_ram_dp.

Verification
REQ-033 DATA_W=16, ADDR_W=3: release rst_n -> init_busy high exactly 8 cycles, then 0; reads of addresses 0..7 return 0x0000.
REQ-034 Write 0xA5C3 to addr 2 with wr_be=2'b01 over CLEAR_VAL 0 -> read addr 2 returns 0x00C3 one cycle after rd_en, with rd_valid pulse of exactly 1 cycle.
REQ-035 mem[5]=0x1111; same cycle write 0x2222 (wr_be=11) and read addr 5 -> RD_MODE=0 returns 0x1111, RD_MODE=1 returns 0x2222; a subsequent read returns 0x2222 in both modes.
REQ-036 Drop rst_n during cycle 4 of CLR, and again in RUN after writing 0xBEEF to addr 7 -> rd_data=0 and rd_valid=0 immediately; a full 8-cycle CLR follows release; addr 7 reads 0x0000.
REQ-037 wr_en/rd_en asserted during CLR -> no write takes effect, rd_valid stays 0.
REQ-038 With SYNC_RAM_DP_PARITY_EN: force a bit flip in stored byte 1 of addr 3 -> read addr 3 gives rd_perr=1 with rd_valid; clean words give rd_perr=0.
